ahb_gpio_arb: RTL and testbench

- Arbitrates NREQ local requesters onto the single-slave GPIO register port (HSEL/HADDR/HWRITE/HWDATA/HRDATA), one access at a time.
- Uses round-robin fairness with a req/ack handshake per requester.
- Sits between the software-visible masters (CPU bridge, DMA, test sequencer) and the GPIO slave, which latches writes at the clock edge where HSEL&HWRITE and returns read data combinationally.

---
 rtl/ahb_gpio_arb_pkg.sv | 8 +
 rtl/ahb_gpio_arb_rr_pick.sv | 25 ++
 rtl/ahb_gpio_arb.sv | 79 +++++++
 tb/tb_ahb_gpio_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_gpio_arb_pkg.sv
// ahb_gpio_arb_pkg: FSM states, GPIO register selects and default sizes for ahb_gpio_arb.
package ahb_gpio_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
  localparam logic GPIO_PORT_ADDR = 1'b0;
  localparam logic GPIO_DIR_ADDR = 1'b1;
  localparam int DEF_NREQ = 2;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/ahb_gpio_arb_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request after ptr, wrapping mod N.
module rr_pick #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    c = 0;
    // scan farthest to nearest so the closest request after ptr wins
    for (int i = N; i >= 1; i--) begin
      c = (int'(ptr) + i) % N;
      if (|(req & (N'(1) << c))) begin
        gnt = N'(1) << c;
        idx = IW'(c);
      end
    end
  end
endmodule

// File: rtl/ahb_gpio_arb.sv
// ahb_gpio_arb: round-robin arbiter of NREQ requesters onto the single GPIO register port.
// Define GPIO_ARB_LOCK_EN to add the lock input that keeps ownership for atomic read-modify-write.
module ahb_gpio_arb
  import ahb_gpio_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW = DEF_DW
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wr,
  input  logic [NREQ-1:0]      addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 HSEL,
  output logic                 HADDR,
  output logic                 HWRITE,
  output logic [DW-1:0]        HWDATA,
  input  logic [DW-1:0]        HRDATA
`ifdef GPIO_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]      lock
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, owner, w;
  logic [NREQ-1:0] elig, gnt;
  logic go;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (.req(elig), .ptr(rr_ptr), .gnt(gnt), .idx(w));
  assign go = |gnt;
`ifdef GPIO_ARB_LOCK_EN
  logic locked, hold;
  // while held, only the owner competes; dropping lock reopens round-robin from owner+1
  assign hold = locked && lock[owner];
  assign elig = hold ? (req & (NREQ'(1) << owner)) : req;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) locked <= 1'b0;
    else if (state == ACK) locked <= lock[owner];
    else if (state == IDLE) locked <= hold;
`else
  assign elig = req;
`endif
  always_comb state_nxt = (state == IDLE) ? (go ? XFER : IDLE) : ((state == XFER) ? ACK : IDLE);
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      HSEL <= 1'b0;
      HADDR <= 1'b0;
      HWRITE <= 1'b0;
      HWDATA <= '0;
      ack <= '0;
      rdata <= '0;
      rr_ptr <= IW'(NREQ - 1);
      owner <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        HSEL <= 1'b1;
        HADDR <= addr[w];
        HWRITE <= wr[w];
        HWDATA <= wdata[int'(w)*DW +: DW];
        owner <= w;
      end
      if (state == XFER) begin
        rdata <= HRDATA;
        HSEL <= 1'b0;
        HADDR <= 1'b0;
        HWRITE <= 1'b0;
        HWDATA <= '0;
        ack <= NREQ'(1) << owner;
        rr_ptr <= owner;
      end
      if (state == ACK) ack <= '0;
    end
  end
endmodule

// File: tb/tb_ahb_gpio_arb.sv
// tb_ahb_gpio_arb: randomized scoreboard bench for ahb_gpio_arb against a behavioural GPIO slave.
// Build with GPIO_ARB_LOCK_EN to also exercise the lock port.
module tb_ahb_gpio_arb;
  localparam int N = 2;
  localparam int DW = 32;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [N-1:0] req = '0, wr = '0, addr = '0, ack;
  logic [N*DW-1:0] wdata = '0;
  logic [DW-1:0] rdata, HWDATA, HRDATA;
  logic HSEL, HADDR, HWRITE;
`ifdef GPIO_ARB_LOCK_EN
  logic [N-1:0] lock = '0;
`endif
  logic [DW-1:0] port_reg, dir_reg;
  logic [DW-1:0] pins = '0;
  logic hsel_prev = 1'b0;
  int compared = 0, mismatched = 0, cyc = 0, last = N - 1;
  typedef struct {int id; logic w; logic a; logic [DW-1:0] d; logic [DW-1:0] r;} txn_t;
  txn_t sb[$];
  logic [DW-1:0] mem[2] = '{default: '0};

  ahb_gpio_arb #(.NREQ(N), .DW(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA)
`ifdef GPIO_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  // GPIO slave: output bits come from PORT where DIR=1, input bits from the pins elsewhere
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      port_reg <= '0;
      dir_reg <= '0;
    end else if (HSEL && HWRITE) begin
      if (HADDR) dir_reg <= HWDATA;
      else port_reg <= HWDATA;
    end
  assign HRDATA = HADDR ? dir_reg : ((port_reg & dir_reg) | (pins & ~dir_reg));

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic void push(int id, logic w, logic a, logic [DW-1:0] d);
    txn_t t;
    t.id = id;
    t.w = w;
    t.a = a;
    t.d = d;
    t.r = a ? mem[1] : ((mem[0] & mem[1]) | (pins & ~mem[1]));
    if (w) mem[a] = d;
    sb.push_back(t);
    last = id;
  endfunction

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (HSEL) begin
        check("hsel_gap", DW'(hsel_prev), '0);
        if (sb.size() == 0) fail("hsel_unexpected");
        else begin
          check("haddr", DW'(HADDR), DW'(sb[0].a));
          check("hwrite", DW'(HWRITE), DW'(sb[0].w));
          if (sb[0].w) check("hwdata", HWDATA, sb[0].d);
        end
      end
      if (ack != '0) begin
        if (sb.size() == 0) fail("ack_unexpected");
        else begin
          txn_t t;
          t = sb.pop_front();
          check("ack_onehot", DW'(ack), DW'(N'(1) << t.id));
          if (!t.w) check("rdata", rdata, t.r);
        end
      end
    end
    hsel_prev = HRESETn && HSEL;
  end

  // k accesses granted in rotation over mask m; held requesters re-request, others drop on ack
  task automatic round(logic [N-1:0] m, logic [N-1:0] w_v, logic [N-1:0] a_v,
                       logic [N*DW-1:0] d_v, bit held, int k);
    int acks[$];
    int p = last, g = 0;
    for (int s = 0; s < k; s++)
      for (int i = 1; i <= N; i++) begin
        int c = (p + i) % N;
        if (m[c]) begin
          push(c, w_v[c], a_v[c], d_v[c*DW +: DW]);
          p = c;
          break;
        end
      end
    @(negedge HCLK);
    wr = w_v;
    addr = a_v;
    wdata = d_v;
    req = m;
    while (req != '0 && g < 40) begin
      @(negedge HCLK);
      g++;
      if (ack != '0) begin
        acks.push_back(cyc);
        req = held ? ((acks.size() >= k) ? '0 : req) : (req & ~ack);
      end
    end
    if (req != '0) begin
      fail("round_timeout");
      req = '0;
      sb.delete();
    end
    for (int i = 1; i < acks.size(); i++) check("ack_spacing", DW'(acks[i] - acks[i-1]), DW'(3));
  endtask

  task automatic single(int id, logic w, logic a, logic [DW-1:0] d);
    push(id, w, a, d);
    @(negedge HCLK);
    req = N'(1) << id;
    wr = w ? req : '0;
    addr = a ? req : '0;
    wdata = '0;
    wdata[id*DW +: DW] = d;
    @(negedge HCLK);
    check("lat_hsel", DW'(HSEL), DW'(1));
    @(negedge HCLK);
    check("lat_ack", DW'(ack), DW'(N'(1) << id));
    req = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_ack", DW'(ack), '0);
    check("rst_rdata", rdata, '0);
    check("rst_hbus", DW'({HSEL, HADDR, HWRITE}), '0);
    check("rst_hwdata", HWDATA, '0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      check("idle_hsel", DW'(HSEL), '0);
    end
    pins = 32'hA5A5_1234;
    single(1, 1'b0, 1'b0, '0);
    check("read_pins", rdata, 32'hA5A5_1234);
    single(0, 1'b1, 1'b1, 32'h0000_00FF);
    check("slave_dir", dir_reg, 32'h0000_00FF);
    round(2'b11, 2'b00, 2'b00, '0, 1'b1, 4);
    push(0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    @(negedge HCLK);
    wr = 2'b01;
    addr = 2'b00;
    wdata = {32'h0, 32'hDEAD_BEEF};
    req = 2'b01;
    @(negedge HCLK);
    check("mid_hsel", DW'(HSEL), DW'(1));
    #1 HRESETn = 1'b0;
    #1;
    check("mid_rst_hsel", DW'(HSEL), '0);
    check("mid_rst_ack", DW'(ack), '0);
    req = '0;
    sb.delete();
    mem[0] = '0;
    mem[1] = '0;
    last = N - 1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) begin
      @(negedge HCLK);
      check("post_rst_idle", DW'({HSEL, ack}), '0);
    end
`ifdef GPIO_ARB_LOCK_EN
    begin
      int n = 0, g = 0;
      push(0, 1'b0, 1'b0, '0);
      push(0, 1'b1, 1'b0, 32'h1357_9BDF);
      push(1, 1'b1, 1'b1, 32'h0F0F_0000);
      @(negedge HCLK);
      wr = 2'b00;
      addr = 2'b00;
      lock = 2'b01;
      req = 2'b01;
      while (n < 3 && g < 40) begin
        @(negedge HCLK);
        g++;
        if (ack != '0) begin
          n++;
          if (n == 1) begin
            wr = 2'b11;
            addr = 2'b10;
            wdata = {32'h0F0F_0000, 32'h1357_9BDF};
            req = 2'b11;
          end else if (n == 2) begin
            lock = '0;
            req = 2'b10;
          end else req = '0;
        end
      end
      if (n < 3) begin
        fail("lock_timeout");
        sb.delete();
        req = '0;
        lock = '0;
      end
    end
`endif
    repeat (40) begin
      logic [N-1:0] m;
      bit held;
      m = N'($urandom_range(1, (1 << N) - 1));
      held = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) pins = $urandom;
      round(m, N'($urandom), N'($urandom), {$urandom, $urandom}, held,
            held ? int'($urandom_range(1, 5)) : $countones(m));
    end
    repeat (3) @(negedge HCLK);
    check("sb_empty", DW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
